opb_master_cmd_initiator: RTL and testbench
===========================================

Name: opb_master_cmd_initiator

Overview:
- Single-beat OPB master (initiator); the other end of the OPB slave registers (simulink2ppc/ppc2simulink) on the ROACH OPB bus.
- Accepts one read or write command from fabric logic over a valid/ready interface and arbitrates for the bus.
- Performs the transfer with retry handling, then returns read data and status on a response port.
- Lets fabric-side control logic read/write software registers (e.g. error counters) without the PPC.

Parameters:
- C_OPB_AWIDTH, 32, address width (fixed 32; bits [0:31], bit 0 MSB).
- C_OPB_DWIDTH, 32, data width (fixed 32; bits [0:31]).
- C_MAX_RETRY, 4, number of OPB_retry responses tolerated before giving up (1..15).

Ports:
- OPB_Clk  in  1  single clock for all logic.
- OPB_Rst_n  in  1  synchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block can accept a command.
- cmd_rnw  in  1  1=read, 0=write.
- cmd_addr  in  [0:31]  byte address.
- cmd_be  in  [0:3]  byte enables.
- cmd_wdata  in  [0:31]  write data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  [0:31]  read data, valid with rsp_valid.
- rsp_status  out  2  00 OK, 01 errAck, 10 timeout, 11 retry exhausted.
- M_request  out  1  bus request to arbiter.
- M_busLock  out  1  tied 0.
- M_select  out  1  transfer in progress.
- M_RNW  out  1  read/not-write.
- M_seqAddr  out  1  tied 0.
- M_ABus  out  [0:31]  address.
- M_BE  out  [0:3]  byte enables.
- M_DBus  out  [0:31]  write data.
- OPB_MGrant  in  1  arbiter grant.
- OPB_xferAck  in  1  slave transfer acknowledge.
- OPB_errAck  in  1  slave error.
- OPB_retry  in  1  slave retry.
- OPB_timeout  in  1  arbiter timeout.
- OPB_DBus  in  [0:31]  read data bus.

Behaviour:
- Everything is registered and acts on rising OPB_Clk edges.
- Reset: OPB_Rst_n=0 at an edge forces the following at that edge:
  - state IDLE;
  - cmd_ready=0 during reset, 1 on the first cycle after release;
  - all M_* outputs 0; rsp_valid=0; rsp_rdata=0; rsp_status=00; retry count 0.
  - Reset mid-transfer abandons the transfer. No response is issued.
- OR-bus rule: M_ABus, M_BE, M_DBus and M_RNW are 0 whenever M_select=0. M_DBus is also 0 on reads.
- States IDLE, REQ, XFER, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch rnw/addr/be/wdata, clear retry count, go to REQ.
  - cmd_ready drops the cycle after acceptance and stays 0 until IDLE is re-entered.
- REQ:
  - M_request=1.
  - If OPB_MGrant=1 is sampled, go to XFER next cycle with M_request=0, M_select=1 and the bus driven from the latches.
- XFER: M_select held until a terminating input. Priority is timeout > errAck > retry > xferAck.
  - OPB_timeout: go to RESP with status 10.
  - OPB_errAck: go to RESP with status 01 and rsp_rdata=0.
  - OPB_retry:
    - Drop M_select next cycle and increment the retry count.
    - If count reaches C_MAX_RETRY, go to RESP with status 11.
    - Otherwise return to REQ.
  - OPB_xferAck: capture OPB_DBus (reads only; writes give 0), go to RESP with status 00.
- RESP:
  - rsp_valid=1 for exactly one cycle, with rsp_rdata/rsp_status held stable.
  - Next state IDLE. rsp_rdata/rsp_status hold until the next response.
- Minimum latency, with same-cycle grant and ack:
  - accept at cycle k; REQ at k+1; XFER at k+2; rsp_valid at k+3; cmd_ready=1 at k+4.
- No backpressure on the response port; the consumer must take the rsp_valid pulse.
- cmd_* inputs are ignored outside IDLE.
- A terminating input arriving while M_select=0 is ignored.

Test Plan:
1. Read 0x01008700 with BE=1111; grant at k+1, xferAck with OPB_DBus=0x0000002A at k+2 -> rsp_valid at k+3, rdata=0x0000002A, status 00, M_select high exactly 1 cycle.
2. Write 0xDEADBEEF to 0x01008800; grant delayed 5 cycles, xferAck after 3 select cycles -> M_DBus=0xDEADBEEF and M_RNW=0 throughout select; rsp status 00, rdata 0; all M_* 0 outside select.
3. Read with retry on 2 attempts then xferAck -> exactly 3 request/select sequences, status 00 with correct data. With C_MAX_RETRY=4 and 4 retries -> status 11 and no 5th request.
4. errAck and xferAck in the same cycle -> status 01, rdata 0. OPB_timeout together with xferAck -> status 10.
5. Assert OPB_Rst_n=0 while in XFER -> next cycle M_select=0, M_request=0, no rsp_valid; cmd_ready=1 on the first cycle after release; a new command then completes normally.
6. Hold cmd_valid high continuously for 3 back-to-back reads -> 3 responses in order, cmd_ready low between acceptance and the cycle after each rsp_valid.

Source files
------------

// File: rtl/opb_master_cmd_initiator.sv
// Single-beat OPB master: takes one fabric command, arbitrates for the bus,
// runs the transfer with retry handling and returns data/status on a response pulse.
module opb_master_cmd_initiator #(
    parameter int unsigned C_OPB_AWIDTH = 32,
    parameter int unsigned C_OPB_DWIDTH = 32,
    parameter int unsigned C_MAX_RETRY  = 4
) (
    input  logic                        OPB_Clk,
    input  logic                        OPB_Rst_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_rnw,
    input  logic [0:C_OPB_AWIDTH-1]     cmd_addr,
    input  logic [0:C_OPB_DWIDTH/8-1]   cmd_be,
    input  logic [0:C_OPB_DWIDTH-1]     cmd_wdata,
    output logic                        rsp_valid,
    output logic [0:C_OPB_DWIDTH-1]     rsp_rdata,
    output logic [1:0]                  rsp_status,
    output logic                        M_request,
    output logic                        M_busLock,
    output logic                        M_select,
    output logic                        M_RNW,
    output logic                        M_seqAddr,
    output logic [0:C_OPB_AWIDTH-1]     M_ABus,
    output logic [0:C_OPB_DWIDTH/8-1]   M_BE,
    output logic [0:C_OPB_DWIDTH-1]     M_DBus,
    input  logic                        OPB_MGrant,
    input  logic                        OPB_xferAck,
    input  logic                        OPB_errAck,
    input  logic                        OPB_retry,
    input  logic                        OPB_timeout,
    input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus
);
    localparam int unsigned BE_W  = C_OPB_DWIDTH / 8;
    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_XFER = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam logic [1:0] RSP_OK  = 2'b00;
    localparam logic [1:0] RSP_ERR = 2'b01;
    localparam logic [1:0] RSP_TMO = 2'b10;
    localparam logic [1:0] RSP_RTY = 2'b11;

    logic [1:0]              state_q, state_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    rnw_q, rnw_d;
    logic [0:C_OPB_AWIDTH-1] addr_q, addr_d;
    logic [0:BE_W-1]         be_q, be_d;
    logic [0:C_OPB_DWIDTH-1] wdata_q, wdata_d;
    logic [CNT_W-1:0]        retry_cnt_q, retry_cnt_d;
    logic                    m_request_q, m_request_d;
    logic                    m_select_q, m_select_d;
    logic                    m_rnw_q, m_rnw_d;
    logic [0:C_OPB_AWIDTH-1] m_abus_q, m_abus_d;
    logic [0:BE_W-1]         m_be_q, m_be_d;
    logic [0:C_OPB_DWIDTH-1] m_dbus_q, m_dbus_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [0:C_OPB_DWIDTH-1] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]              rsp_status_q, rsp_status_d;

    // Next-state and registered-output logic; bus fields are zero whenever select is low.
    always_comb begin
        state_d      = state_q;
        cmd_ready_d  = cmd_ready_q;
        rnw_d        = rnw_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        retry_cnt_d  = retry_cnt_q;
        m_request_d  = m_request_q;
        m_select_d   = m_select_q;
        m_rnw_d      = m_rnw_q;
        m_abus_d     = m_abus_q;
        m_be_d       = m_be_q;
        m_dbus_d     = m_dbus_q;
        rsp_valid_d  = 1'b0;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_status_d = rsp_status_q;

        case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    rnw_d       = cmd_rnw;
                    addr_d      = cmd_addr;
                    be_d        = cmd_be;
                    wdata_d     = cmd_wdata;
                    retry_cnt_d = '0;
                    cmd_ready_d = 1'b0;
                    m_request_d = 1'b1;
                    state_d     = ST_REQ;
                end
            end
            ST_REQ: begin
                m_request_d = 1'b1;
                if (OPB_MGrant) begin
                    m_request_d = 1'b0;
                    m_select_d  = 1'b1;
                    m_rnw_d     = rnw_q;
                    m_abus_d    = addr_q;
                    m_be_d      = be_q;
                    m_dbus_d    = rnw_q ? '0 : wdata_q;
                    state_d     = ST_XFER;
                end
            end
            ST_XFER: begin
                if (OPB_timeout || OPB_errAck || OPB_retry || OPB_xferAck) begin
                    m_select_d = 1'b0;
                    m_rnw_d    = 1'b0;
                    m_abus_d   = '0;
                    m_be_d     = '0;
                    m_dbus_d   = '0;
                    state_d    = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    if (OPB_timeout) begin
                        rsp_status_d = RSP_TMO;
                    end else if (OPB_errAck) begin
                        rsp_status_d = RSP_ERR;
                    end else if (OPB_retry) begin
                        retry_cnt_d = retry_cnt_q + CNT_W'(1);
                        if (retry_cnt_d == CNT_W'(C_MAX_RETRY)) begin
                            rsp_status_d = RSP_RTY;
                        end else begin
                            // Re-arbitrate: no response yet, keep the previous one visible.
                            state_d      = ST_REQ;
                            m_request_d  = 1'b1;
                            rsp_valid_d  = 1'b0;
                            rsp_rdata_d  = rsp_rdata_q;
                        end
                    end else begin
                        rsp_status_d = RSP_OK;
                        rsp_rdata_d  = rnw_q ? OPB_DBus : '0;
                    end
                end
            end
            ST_RESP: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge OPB_Clk) begin
        if (!OPB_Rst_n) begin
            state_q      <= ST_IDLE;
            cmd_ready_q  <= 1'b0;
            rnw_q        <= 1'b0;
            addr_q       <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
            retry_cnt_q  <= '0;
            m_request_q  <= 1'b0;
            m_select_q   <= 1'b0;
            m_rnw_q      <= 1'b0;
            m_abus_q     <= '0;
            m_be_q       <= '0;
            m_dbus_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_status_q <= RSP_OK;
        end else begin
            state_q      <= state_d;
            cmd_ready_q  <= cmd_ready_d;
            rnw_q        <= rnw_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            retry_cnt_q  <= retry_cnt_d;
            m_request_q  <= m_request_d;
            m_select_q   <= m_select_d;
            m_rnw_q      <= m_rnw_d;
            m_abus_q     <= m_abus_d;
            m_be_q       <= m_be_d;
            m_dbus_q     <= m_dbus_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_status_q <= rsp_status_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_status = rsp_status_q;
    assign M_request  = m_request_q;
    assign M_busLock  = 1'b0;
    assign M_select   = m_select_q;
    assign M_RNW      = m_rnw_q;
    assign M_seqAddr  = 1'b0;
    assign M_ABus     = m_abus_q;
    assign M_BE       = m_be_q;
    assign M_DBus     = m_dbus_q;

endmodule

// File: tb/tb_opb_master_cmd_initiator.sv
// Directed bench for opb_master_cmd_initiator: bus-slave/arbiter model in the stimulus
// tasks, response scoreboard on the rsp port, OR-bus rule checker every cycle.
module tb_opb_master_cmd_initiator;
    localparam int unsigned MAX_RETRY = 4;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_rnw;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_be;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_status;
    logic        M_request, M_busLock, M_select, M_RNW, M_seqAddr;
    logic [31:0] M_ABus, M_DBus;
    logic [3:0]  M_BE;
    logic        OPB_MGrant, OPB_xferAck, OPB_errAck, OPB_retry, OPB_timeout;
    logic [31:0] OPB_DBus;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;
    logic [33:0] sb[$];

    opb_master_cmd_initiator #(
        .C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32), .C_MAX_RETRY(MAX_RETRY)
    ) dut (
        .OPB_Clk(clk), .OPB_Rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
        .cmd_addr(cmd_addr), .cmd_be(cmd_be), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
        .M_request(M_request), .M_busLock(M_busLock), .M_select(M_select),
        .M_RNW(M_RNW), .M_seqAddr(M_seqAddr), .M_ABus(M_ABus), .M_BE(M_BE),
        .M_DBus(M_DBus), .OPB_MGrant(OPB_MGrant), .OPB_xferAck(OPB_xferAck),
        .OPB_errAck(OPB_errAck), .OPB_retry(OPB_retry), .OPB_timeout(OPB_timeout),
        .OPB_DBus(OPB_DBus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every response pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (chk_en && rsp_valid === 1'b1) begin
            if (sb.size() == 0) chk("sb_unexpected", 72'(rsp_valid), 72'd0);
            else chk("rsp_data_status", {rsp_status, rsp_rdata}, sb.pop_front());
        end
    end

    // OR-bus rule: all address/data/control fields are zero while not selected.
    always @(negedge clk) begin
        if (chk_en) begin
            if (M_select !== 1'b1) chk("orbus_idle", {M_RNW, M_ABus, M_BE, M_DBus}, 72'd0);
            else if (M_RNW === 1'b1) chk("orbus_rd_dbus", 72'(M_DBus), 72'd0);
        end
    end

    // term: 0 xferAck, 1 errAck+xferAck, 2 timeout+xferAck
    task automatic do_txn(input logic rnw, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, input int gdly, input int sdly,
                          input int nretry, input int term, input logic [31:0] rd,
                          input bit spur, input bit hold);
        logic [1:0]  exp_st;
        logic [31:0] exp_rd;
        int n, reqs, att, exp_reqs;
        bit done;
        if (nretry >= int'(MAX_RETRY)) begin exp_st = 2'b11; exp_rd = 32'h0; end
        else if (term == 1) begin exp_st = 2'b01; exp_rd = 32'h0; end
        else if (term == 2) begin exp_st = 2'b10; exp_rd = 32'h0; end
        else begin exp_st = 2'b00; exp_rd = rnw ? rd : 32'h0; end
        exp_reqs = (nretry >= int'(MAX_RETRY)) ? int'(MAX_RETRY) : nretry + 1;

        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin tick(); n++; end
        chk("cmd_ready_wait", 72'(cmd_ready), 72'd1);
        cmd_rnw = rnw; cmd_addr = addr; cmd_be = be; cmd_wdata = wd; cmd_valid = 1'b1;
        tick();
        if (!hold) cmd_valid = 1'b0;
        sb.push_back({exp_st, exp_rd});

        reqs = 0; att = 0; done = 0;
        while (!done) begin
            n = 0;
            while (M_request !== 1'b1 && n < 20) begin tick(); n++; end
            chk("req_seen", {M_request, M_select}, 72'b10);
            if (M_request !== 1'b1) return;
            reqs++;
            for (int i = 0; i < gdly; i++) begin
                if (spur) begin OPB_xferAck = 1'b1; OPB_errAck = 1'b1; end
                tick();
                chk("req_hold", {M_request, M_select, cmd_ready}, 72'b100);
            end
            OPB_xferAck = 1'b0; OPB_errAck = 1'b0;
            OPB_MGrant = 1'b1;
            tick();
            OPB_MGrant = 1'b0;
            for (int i = 0; i <= sdly; i++) begin
                chk("sel_bus", {M_select, M_request, M_RNW, M_ABus, M_BE, M_DBus, cmd_ready},
                    {1'b1, 1'b0, rnw, addr, be, rnw ? 32'h0 : wd, 1'b0});
                if (i == sdly) begin
                    OPB_DBus = rd;
                    if (att < nretry) OPB_retry = 1'b1;
                    else begin
                        OPB_xferAck = 1'b1;
                        OPB_errAck  = (term == 1);
                        OPB_timeout = (term == 2);
                    end
                end
                tick();
            end
            OPB_retry = 1'b0; OPB_xferAck = 1'b0; OPB_errAck = 1'b0; OPB_timeout = 1'b0;
            OPB_DBus = 32'h0;
            if (att < nretry) begin
                att++;
                if (att >= int'(MAX_RETRY)) done = 1;
            end else begin
                done = 1;
            end
        end
        chk("req_count", 72'(reqs), 72'(exp_reqs));
        chk("rsp_pulse", {rsp_valid, cmd_ready, M_select, M_request}, 72'b1000);
        tick();
        chk("rsp_after", {rsp_valid, cmd_ready, M_select, M_request}, 72'b0100);
        chk("rsp_hold", {rsp_status, rsp_rdata}, {exp_st, exp_rd});
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_rnw = 1'b0; cmd_addr = '0; cmd_be = '0;
        cmd_wdata = '0; OPB_MGrant = 1'b0; OPB_xferAck = 1'b0; OPB_errAck = 1'b0;
        OPB_retry = 1'b0; OPB_timeout = 1'b0; OPB_DBus = '0;
        tick(); tick(); tick();
        chk_en = 1;
        chk("reset_outputs", {cmd_ready, rsp_valid, rsp_status, rsp_rdata, M_request,
                              M_select, M_busLock, M_seqAddr}, 72'd0);
        rst_n = 1'b1;
        tick();
        chk("ready_after_reset", 72'(cmd_ready), 72'd1);

        // 1: single read, same-cycle grant and ack
        do_txn(1'b1, 32'h0100_8700, 4'hF, 32'h0, 0, 0, 0, 0, 32'h0000_002A, 0, 0);
        // 2: write, delayed grant, spurious acks while unselected, ack after 3 select cycles
        do_txn(1'b0, 32'h0100_8800, 4'hF, 32'hDEAD_BEEF, 5, 3, 0, 0, 32'h1234_5678, 1, 0);
        // 3: two retries then ack; then retries exhausted
        do_txn(1'b1, 32'h0100_8704, 4'hF, 32'h0, 1, 0, 2, 0, 32'hCAFE_0001, 0, 0);
        do_txn(1'b1, 32'h0100_8708, 4'b0011, 32'h0, 0, 1, 4, 0, 32'h0000_0055, 0, 0);
        repeat (3) begin
            tick();
            chk("no_extra_request", {M_request, M_select}, 72'd0);
        end
        // 4: priority of errAck and timeout over xferAck
        do_txn(1'b1, 32'h0100_870C, 4'hF, 32'h0, 0, 0, 0, 1, 32'hFFFF_FFFF, 0, 0);
        do_txn(1'b0, 32'h0100_8810, 4'b1000, 32'hA5A5_A5A5, 2, 0, 0, 2, 32'h7777_7777, 0, 0);

        // 5: reset while selected abandons the transfer
        cmd_rnw = 1'b1; cmd_addr = 32'h0100_8714; cmd_be = 4'hF; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        OPB_MGrant = 1'b1;
        tick();
        OPB_MGrant = 1'b0;
        chk("rst_in_xfer", {M_select, M_request}, 72'b10);
        rst_n = 1'b0;
        tick();
        chk("rst_abandon", {M_select, M_request, rsp_valid, cmd_ready}, 72'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_release", {cmd_ready, rsp_valid, M_request}, 72'b100);
        do_txn(1'b1, 32'h0100_8718, 4'hF, 32'h0, 0, 0, 0, 0, 32'h0BAD_F00D, 0, 0);

        // 6: back-to-back reads with cmd_valid held high
        do_txn(1'b1, 32'h0100_8720, 4'hF, 32'h0, 0, 0, 0, 0, 32'h1111_0001, 0, 1);
        do_txn(1'b1, 32'h0100_8724, 4'hF, 32'h0, 1, 0, 0, 0, 32'h2222_0002, 0, 1);
        do_txn(1'b1, 32'h0100_8728, 4'hF, 32'h0, 0, 2, 0, 0, 32'h3333_0003, 0, 1);
        cmd_valid = 1'b0;
        tick(); tick();
        chk("sb_empty", 72'(sb.size()), 72'd0);
        chk("final_idle", {cmd_ready, M_request, rsp_valid}, 72'b100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
